// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_rx serial receiver.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } sipo_state_e;

    localparam int unsigned SIPO_WIDTH_DEF = 4;

    // Ceiling log2, minimum 1; used to size the bit counter as clog2(WIDTH+1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and frame FSM for sipo_rx.
// Optional trailing even-parity bit when SIPO_RX_PARITY_CHECK_EN is defined.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH_DEF,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic             sync,
    output logic             frame_done,
    output logic [WIDTH-1:0] word,
    output logic             word_perr,
    output logic             busy
);

    localparam int unsigned CW = clog2(WIDTH + 1);

    sipo_state_e      state_r, state_n, base_state_s;
    logic [WIDTH-1:0] shreg_r, shreg_n, base_shreg_s, shifted_s;
    logic [CW-1:0]    cnt_r, cnt_n, base_cnt_s;
    logic             busy_r;

    function automatic logic calc_perr(input logic [WIDTH-1:0] w, input logic p);
        return (^w) ^ p;
    endfunction

    // Next-state: sync first wipes the partial frame, then an accepted bit is applied.
    always_comb begin
        base_shreg_s = sync ? {WIDTH{1'b0}} : shreg_r;
        base_cnt_s   = sync ? {CW{1'b0}} : cnt_r;
        base_state_s = sync ? IDLE : state_r;
        if (MSB_FIRST != 0) begin
            shifted_s = {base_shreg_s[WIDTH-2:0], in};
        end else begin
            shifted_s = {in, base_shreg_s[WIDTH-1:1]};
        end
        shreg_n    = base_shreg_s;
        cnt_n      = base_cnt_s;
        state_n    = base_state_s;
        frame_done = 1'b0;
        word       = shifted_s;
        word_perr  = 1'b0;
        if (in_valid) begin
            case (base_state_s)
                IDLE, RECV: begin
                    shreg_n = shifted_s;
                    if (base_cnt_s == CW'(WIDTH - 1)) begin
`ifdef SIPO_RX_PARITY_CHECK_EN
                        cnt_n   = CW'(WIDTH);
                        state_n = PAR;
`else
                        frame_done = 1'b1;
                        cnt_n      = {CW{1'b0}};
                        state_n    = IDLE;
`endif
                    end else begin
                        cnt_n   = base_cnt_s + CW'(1);
                        state_n = RECV;
                    end
                end
                PAR: begin
`ifdef SIPO_RX_PARITY_CHECK_EN
                    frame_done = 1'b1;
                    word       = base_shreg_s;
                    word_perr  = calc_perr(base_shreg_s, in);
`endif
                    cnt_n   = {CW{1'b0}};
                    state_n = IDLE;
                end
                default: begin
                    cnt_n   = {CW{1'b0}};
                    state_n = IDLE;
                end
            endcase
        end else begin
            shreg_n = base_shreg_s;
        end
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            shreg_r <= shreg_n;
            cnt_r   <= cnt_n;
            busy_r  <= (state_n != IDLE);
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver with one-word valid/ready holding register.
// Define SIPO_RX_PARITY_CHECK_EN to expect a trailing even-parity bit per word.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = SIPO_WIDTH_DEF,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    logic             frame_done_s;
    logic [WIDTH-1:0] word_s;
    logic             word_perr_s;
    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;
    logic             overrun_r;
    logic             perr_r;
    logic             can_load_s;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .in_valid   (in_valid),
        .sync       (sync),
        .frame_done (frame_done_s),
        .word       (word_s),
        .word_perr  (word_perr_s),
        .busy       (busy)
    );

    // A new word may land when the slot is empty or is being drained this edge.
    assign can_load_s = !out_valid_r || out_ready;

    // Holding register, handshake and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
            perr_r      <= 1'b0;
        end else begin
            if (frame_done_s && can_load_s) begin
                out_r       <= word_s;
                perr_r      <= word_perr_s;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (sync) begin
                overrun_r <= 1'b0;
            end else if (frame_done_s && !can_load_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign overrun   = overrun_r;
`ifdef SIPO_RX_PARITY_CHECK_EN
    assign parity_err = perr_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule
